note_tx_arbiter: RTL and testbench
==================================

# note_tx_arbiter

Shares one byte-level UART transmitter between the left-hand and right-hand note streams of the Magic Tiles song player. Each hand presents 7-bit note records (tile[6:3], duration[2:0]) on a valid/ready handshake. The block picks between hands round-robin, frames the accepted note as three ASCII bytes (hand tag, tile letter, duration digit) and sequences them through the UART's start/ready handshake. It sits between the per-hand music ROM sequencers and the single `music_uart` instance.

## Interface
- `BUSY_TIMEOUT`, default 16: maximum cycles to wait for `tx_ready` to drop after `tx_start`. On expiry the byte is treated as accepted.
- `CNT_W`, default 16: width of `frame_cnt`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  high allows new notes to be accepted. Low lets an in-flight frame finish.
- `l_valid`  in  1  left-hand note available.
- `l_note`  in  7  left-hand record: tile in [6:3], duration in [2:0].
- `l_ready`  out  1  left note accepted this cycle.
- `r_valid`, `r_note`, `r_ready`: same as the left-hand ports, for the right hand.
- `tx_data`  out  8  byte to the UART.
- `tx_start`  out  1  one-cycle start strobe to the UART.
- `tx_ready`  in  1  UART idle/ready.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `last_r`  out  1  hand of the last grant: 1 = right, 0 = left.
- `frame_cnt`  out  CNT_W  number of completed frames; wraps to 0.
- `err_dur`  out  1  one-cycle pulse when an accepted note has an illegal duration code.
- `timeout`  out  1  one-cycle pulse when `BUSY_TIMEOUT` expires.

## Operation
- **FSM states:** IDLE, SEND, WAIT_LOW, WAIT_HIGH. Byte index `bi` runs 0..2.
- **Arbitration (IDLE):**
  - The favored hand is the opposite of `last_r`.
  - If `en` is high and both hands are valid, grant the favored hand. If only one is valid, grant it.
  - `x_ready = (state==IDLE) & en & grant_x`, combinational. At most one ready is high.
  - A transfer happens on a clock edge with valid & ready.
  - On transfer: latch the note, update `last_r`, set `bi` to 0, go to SEND.
- **Frame bytes:**
  - byte0 = 0x4C ('L') or 0x52 ('R').
  - byte1 = 0x41 + tile (8-bit add; tile 15 gives 0x50).
  - byte2 = 0x32 ('2') for duration 3'b010, 0x34 ('4') for 3'b100, otherwise 0x58 ('X').
  - An 'X' byte also raises `err_dur` in the cycle after acceptance. The frame is still sent.
- **SEND:** wait for `tx_ready` high. Then drive `tx_data` = byte[`bi`] and `tx_start` = 1 for exactly one cycle, clear the timeout counter, go to WAIT_LOW.
- **WAIT_LOW:**
  - `tx_ready` low: go to WAIT_HIGH.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`, pulse `timeout` and go to WAIT_HIGH.
- **WAIT_HIGH:** wait for `tx_ready` high.
  - If `bi` == 2: increment `frame_cnt`, go to IDLE.
  - Otherwise increment `bi`, go to SEND.
- **`en` deasserted mid-frame:** no effect until IDLE is reached, then no new grants.
- **Reset values:** all outputs 0 (`tx_data` 0x00, `last_r` 0, so left is favored first), state IDLE, counters 0.
- **Reset mid-frame:** the frame is abandoned immediately, `tx_start` goes to 0 asynchronously, and no partial-frame count is recorded.

## Timing
- Acceptance at edge N gives `tx_start` high in cycle N+1 if `tx_ready` is already high.
- `tx_data` is valid in the `tx_start` cycle and holds its value until the next byte is loaded.
- Per byte: 1 start cycle, plus the UART busy time, plus 1 cycle to observe `tx_ready` high.
- Next grant: at the earliest, the cycle after returning to IDLE.
- Back-to-back notes from the same hand are possible only when the other hand is not valid.
- `frame_cnt` updates on the edge leaving WAIT_HIGH for byte 2.
- `err_dur` and `timeout` are single-cycle pulses.

## Structure
- Shared package `note_pkg` holds:
  - note field positions (TILE_MSB = 6, TILE_LSB = 3, DUR_MSB = 2);
  - duration codes DUR_HALF = 3'b010 and DUR_FULL = 3'b100;
  - ASCII constants (tag L/R, 'A', '2', '4', 'X');
  - the FSM state encoding.
- One sub-module, `note_byte_encoder`: combinational map of (hand, note, `bi`) to byte plus a `bad_dur` flag. The FSM, arbiter and counters live in `note_tx_arbiter`.

## Test plan
- Left only, note 7'b0101_010, UART model with 4-cycle busy: bytes 0x4C, 0x46, 0x32 in order, one `tx_start` each, `frame_cnt` = 1.
- Both valid continuously, left {0000_100}, right {1100_010}: frames alternate L, R, L, R starting with L after reset; the `l_ready`/`r_ready` pulses never overlap.
- Right note 7'b0011_111: byte2 = 0x58, `err_dur` pulses once, `frame_cnt` still increments.
- UART model that never drops `tx_ready`, `BUSY_TIMEOUT` = 16: `timeout` pulses 3 times, the frame completes, and the FSM returns to IDLE.
- `en` dropped during byte1 of a left frame while right is valid: the frame finishes, `r_ready` stays 0 until `en` returns, then the right frame is sent.
- `rst` asserted in WAIT_LOW of byte1: outputs return to their reset values immediately. After release, a new left frame restarts at byte0, and `frame_cnt` excludes the aborted frame.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note transmit path: record layout, duration codes,
// ASCII framing characters and the transmit FSM state encoding.
package note_pkg;

    localparam int TILE_MSB = 6;
    localparam int TILE_LSB = 3;
    localparam int DUR_MSB  = 2;

    localparam logic [DUR_MSB:0] DUR_HALF = 3'b010;
    localparam logic [DUR_MSB:0] DUR_FULL = 3'b100;

    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_2 = 8'h32;
    localparam logic [7:0] ASCII_4 = 8'h34;
    localparam logic [7:0] ASCII_X = 8'h58;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } tx_state_t;

    function automatic logic dur_is_legal(input logic [DUR_MSB:0] dur);
        return (dur == DUR_HALF) || (dur == DUR_FULL);
    endfunction

endpackage

// File: rtl/note_byte_encoder.sv
// Maps (hand, note record, byte index) to one ASCII frame byte and flags
// duration codes that have no printable digit.
module note_byte_encoder
    import note_pkg::*;
(
    input  logic       hand,
    input  logic [6:0] note,
    input  logic [1:0] bi,
    output logic [7:0] byte_out,
    output logic       bad_dur
);

    logic [3:0]       tile;
    logic [DUR_MSB:0] dur;
    logic [7:0]       dur_char;

    assign tile    = note[TILE_MSB:TILE_LSB];
    assign dur     = note[DUR_MSB:0];
    assign bad_dur = !dur_is_legal(dur);

    always_comb begin
        dur_char = ASCII_X;
        if (dur == DUR_HALF)
            dur_char = ASCII_2;
        else if (dur == DUR_FULL)
            dur_char = ASCII_4;
    end

    always_comb begin
        case (bi)
            2'd1:    byte_out = ASCII_A + {4'b0000, tile};
            2'd2:    byte_out = dur_char;
            default: byte_out = hand ? ASCII_R : ASCII_L;
        endcase
    end

endmodule

// File: rtl/note_tx_arbiter.sv
// Round-robin arbiter between the left/right note streams that frames each
// accepted note as three ASCII bytes and paces them through the UART handshake.
module note_tx_arbiter
    import note_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             l_valid,
    input  logic [6:0]       l_note,
    output logic             l_ready,
    input  logic             r_valid,
    input  logic [6:0]       r_note,
    output logic             r_ready,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_ready,
    output logic             busy,
    output logic             last_r,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err_dur,
    output logic             timeout
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_t        state_reg, state_next;
    logic [1:0]       bi_reg, bi_next;
    logic [6:0]       note_reg, note_next;
    logic             last_r_reg, last_r_next;
    logic             granted_reg, granted_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             err_dur_reg, err_dur_next;
    logic             timeout_reg, timeout_next;

    logic       favor_r, grant_l, grant_r, take_l, take_r, take;
    logic       enc_hand, enc_bad;
    logic [6:0] enc_note;
    logic [7:0] enc_byte;

    // last_r resets to 0 but the left hand must win the very first tie, so the
    // "opposite of last grant" rule only applies once something has been granted.
    assign favor_r = granted_reg & ~last_r_reg;
    assign grant_l = l_valid & (~r_valid | ~favor_r);
    assign grant_r = r_valid & (~l_valid | favor_r);

    assign l_ready = rst & (state_reg == IDLE) & en & grant_l;
    assign r_ready = rst & (state_reg == IDLE) & en & grant_r;
    assign take_l  = l_valid & l_ready;
    assign take_r  = r_valid & r_ready;
    assign take    = take_l | take_r;

    // In IDLE the encoder looks at the incoming note so err_dur can be registered
    // on the acceptance edge; afterwards it serialises the latched note.
    assign enc_hand = (state_reg == IDLE) ? take_r : last_r_reg;
    assign enc_note = (state_reg == IDLE) ? (take_r ? r_note : l_note) : note_reg;

    note_byte_encoder u_encoder (
        .hand     (enc_hand),
        .note     (enc_note),
        .bi       (bi_reg),
        .byte_out (enc_byte),
        .bad_dur  (enc_bad)
    );

    assign tx_start  = (state_reg == SEND) & tx_ready;
    assign tx_data   = tx_start ? enc_byte : tx_data_reg;
    assign busy      = (state_reg != IDLE);
    assign last_r    = last_r_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_dur   = err_dur_reg;
    assign timeout   = timeout_reg;

    always_comb begin
        state_next     = state_reg;
        bi_next        = bi_reg;
        note_next      = note_reg;
        last_r_next    = last_r_reg;
        granted_next   = granted_reg;
        tmo_next       = tmo_reg;
        frame_cnt_next = frame_cnt_reg;
        tx_data_next   = tx_data_reg;
        err_dur_next   = 1'b0;
        timeout_next   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (take) begin
                    note_next    = enc_note;
                    last_r_next  = take_r;
                    granted_next = 1'b1;
                    bi_next      = 2'd0;
                    err_dur_next = enc_bad;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_data_next = enc_byte;
                    tmo_next     = '0;
                    state_next   = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!tx_ready) begin
                    state_next = WAIT_HIGH;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                    if (tmo_next == TMO_W'(BUSY_TIMEOUT)) begin
                        timeout_next = 1'b1;
                        state_next   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    if (bi_reg == 2'd2) begin
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                        state_next     = IDLE;
                    end else begin
                        bi_next    = bi_reg + 2'd1;
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bi_reg        <= 2'd0;
            note_reg      <= 7'd0;
            last_r_reg    <= 1'b0;
            granted_reg   <= 1'b0;
            tmo_reg       <= '0;
            frame_cnt_reg <= '0;
            tx_data_reg   <= 8'h00;
            err_dur_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bi_reg        <= bi_next;
            note_reg      <= note_next;
            last_r_reg    <= last_r_next;
            granted_reg   <= granted_next;
            tmo_reg       <= tmo_next;
            frame_cnt_reg <= frame_cnt_next;
            tx_data_reg   <= tx_data_next;
            err_dur_reg   <= err_dur_next;
            timeout_reg   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_note_tx_arbiter.sv
// Directed and randomized checks of note_tx_arbiter against a frame-level
// reference model, with a responding UART model and queue-fed note sources.
module tb_note_tx_arbiter;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             l_valid = 1'b0;
    logic [6:0]       l_note = 7'd0;
    logic             r_valid = 1'b0;
    logic [6:0]       r_note = 7'd0;
    logic             tx_ready = 1'b1;
    logic             l_ready, r_ready, tx_start, busy, last_r, err_dur, timeout;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] frame_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    note_tx_arbiter #(.BUSY_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .l_valid   (l_valid),
        .l_note    (l_note),
        .l_ready   (l_ready),
        .r_valid   (r_valid),
        .r_note    (r_note),
        .r_ready   (r_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .last_r    (last_r),
        .frame_cnt (frame_cnt),
        .err_dur   (err_dur),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Note sources: each hand offers the next unconsumed entry of its queue.
    logic [6:0] l_src[$];
    logic [6:0] r_src[$];
    int l_taken = 0;
    int r_taken = 0;

    always @(posedge clk) begin
        #1;
        l_valid = (l_taken < l_src.size());
        l_note  = l_valid ? l_src[l_taken] : 7'd0;
        r_valid = (r_taken < r_src.size());
        r_note  = r_valid ? r_src[r_taken] : 7'd0;
    end

    function automatic bit legal(input logic [6:0] n);
        return (n[2:0] == 3'b010) || (n[2:0] == 3'b100);
    endfunction

    // UART responder plus observation of every handshake, sampled mid-cycle.
    int busy_len = 4;
    logic [7:0] got[$];
    int n_start = 0, n_err = 0, n_tmo = 0, overlap = 0, err_bad_timing = 0;
    int busy_ctr = 0;
    bit drop_pend = 0;
    bit prev_bad = 0;

    always @(negedge clk) begin
        if (!rst) begin
            tx_ready  = 1'b1;
            busy_ctr  = 0;
            drop_pend = 0;
            prev_bad  = 0;
        end else begin
            if (drop_pend) begin
                drop_pend = 0;
                tx_ready  = 1'b0;
                busy_ctr  = busy_len;
            end else if (busy_ctr > 0) begin
                busy_ctr--;
                if (busy_ctr == 0) tx_ready = 1'b1;
            end
            if (tx_start) begin
                got.push_back(tx_data);
                n_start++;
                $display("tx byte %02h at %0t", tx_data, $time);
                if (busy_len > 0) drop_pend = 1;
            end
            if (err_dur) n_err++;
            if (timeout) n_tmo++;
            if (err_dur !== prev_bad) err_bad_timing++;
            prev_bad = 0;
            if (l_ready && r_ready) overlap++;
            if (l_valid && l_ready) begin
                l_taken++;
                prev_bad = !legal(l_note);
            end
            if (r_valid && r_ready) begin
                r_taken++;
                prev_bad = !legal(r_note);
            end
        end
    end

    // Reference: expected byte stream built frame by frame from the note rules.
    logic [7:0] exp_q[$];

    function automatic void push_frame(input bit hand, input logic [6:0] n);
        logic [7:0] c;
        exp_q.push_back(hand ? 8'h52 : 8'h4C);
        exp_q.push_back(8'h41 + {4'b0000, n[6:3]});
        case (n[2:0])
            3'b010:  c = 8'h32;
            3'b100:  c = 8'h34;
            default: c = 8'h58;
        endcase
        exp_q.push_back(c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_bytes(input string tag);
        int mism = 0;
        int first = -1;
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("first byte difference at %0d: got %02h want %02h", first, got[first], exp_q[first]);
        check({tag, "_bytes"}, mism, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && l_valid === 1'b0 && r_valid === 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(n < 4000), 1);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n = 0;
        while (n_start < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_in_time"}, 32'(n < 4000), 1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (!(int'(frame_cnt) == target && busy === 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_in_time"}, 32'(n < 4000), 1);
    endtask

    int exp_fc = 0;
    int s0, e0, t0, rg0;
    int nl, nr, li, ri, nbad;
    bit m_last, pick_r;
    logic [6:0] ln[$];
    logic [6:0] rn[$];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_last_r", 32'(last_r), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_pulses_readies", 32'({err_dur, timeout, l_ready, r_ready}), 0);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);

        // Both hands continuously valid: L, R, L, R from reset.
        busy_len = 4;
        l_src.push_back(7'b0000_100); l_src.push_back(7'b0000_100);
        r_src.push_back(7'b1100_010); r_src.push_back(7'b1100_010);
        push_frame(0, 7'b0000_100); push_frame(1, 7'b1100_010);
        push_frame(0, 7'b0000_100); push_frame(1, 7'b1100_010);
        exp_fc += 4;
        wait_idle("alt");
        check_bytes("alt");
        check("alt_overlap", overlap, 0);
        check("alt_frame_cnt", 32'(frame_cnt), exp_fc);
        check("alt_last_r", 32'(last_r), 1);

        // Left only.
        s0 = n_start;
        l_src.push_back(7'b0101_010);
        push_frame(0, 7'b0101_010);
        exp_fc++;
        wait_idle("left");
        check_bytes("left");
        check("left_starts", n_start - s0, 3);
        check("left_frame_cnt", 32'(frame_cnt), exp_fc);

        // Illegal duration is still sent, with one err_dur pulse.
        e0 = n_err;
        r_src.push_back(7'b0011_111);
        push_frame(1, 7'b0011_111);
        exp_fc++;
        wait_idle("bad_dur");
        check_bytes("bad_dur");
        check("bad_dur_pulses", n_err - e0, 1);
        check("bad_dur_frame_cnt", 32'(frame_cnt), exp_fc);

        // UART that never drops ready: every byte times out.
        busy_len = 0;
        t0 = n_tmo;
        l_src.push_back(7'b0111_100);
        push_frame(0, 7'b0111_100);
        exp_fc++;
        wait_idle("tmo");
        check_bytes("tmo");
        check("tmo_pulses", n_tmo - t0, 3);
        check("tmo_frame_cnt", 32'(frame_cnt), exp_fc);
        busy_len = 4;

        // en dropped during byte1 of a left frame while right is waiting.
        s0  = n_start;
        rg0 = r_taken;
        l_src.push_back(7'b1001_100);
        push_frame(0, 7'b1001_100);
        exp_fc++;
        wait_starts(s0 + 2, "en_drop");
        en = 1'b0;
        r_src.push_back(7'b0010_010);
        wait_frames(exp_fc, "en_drop");
        repeat (8) @(negedge clk);
        check("en_low_r_ready", 32'(r_ready), 0);
        check("en_low_no_grant", r_taken - rg0, 0);
        check("en_low_busy", 32'(busy), 0);
        en = 1'b1;
        push_frame(1, 7'b0010_010);
        exp_fc++;
        wait_idle("en_back");
        check_bytes("en_back");
        check("en_back_frame_cnt", 32'(frame_cnt), exp_fc);

        // Reset while waiting for the UART during byte1.
        s0 = n_start;
        l_src.push_back(7'b0110_100);
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h47);
        wait_starts(s0 + 2, "abort");
        @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("abort_tx_start", 32'(tx_start), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_tx_data", 32'(tx_data), 0);
        check("abort_frame_cnt", 32'(frame_cnt), 0);
        check("abort_last_r", 32'(last_r), 0);
        exp_fc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        l_src.push_back(7'b0001_010);
        push_frame(0, 7'b0001_010);
        exp_fc++;
        wait_idle("restart");
        check_bytes("restart");
        check("restart_frame_cnt", 32'(frame_cnt), exp_fc);

        // Randomized rounds: both queues loaded at once, arbitration predicted per frame.
        m_last = 1'b0;
        for (int round = 0; round < 3; round++) begin
            busy_len = $urandom_range(1, 4);
            nl = $urandom_range(2, 5);
            nr = $urandom_range(2, 5);
            ln.delete();
            rn.delete();
            for (int i = 0; i < nl; i++) ln.push_back(7'($urandom));
            for (int i = 0; i < nr; i++) rn.push_back(7'($urandom));
            foreach (ln[i]) l_src.push_back(ln[i]);
            foreach (rn[i]) r_src.push_back(rn[i]);
            e0 = n_err;
            li = 0;
            ri = 0;
            nbad = 0;
            while (li < nl || ri < nr) begin
                if (li < nl && ri < nr) pick_r = !m_last;
                else pick_r = (ri < nr);
                if (pick_r) begin
                    push_frame(1, rn[ri]);
                    nbad += legal(rn[ri]) ? 0 : 1;
                    ri++;
                end else begin
                    push_frame(0, ln[li]);
                    nbad += legal(ln[li]) ? 0 : 1;
                    li++;
                end
                m_last = pick_r;
                exp_fc++;
            end
            wait_idle("rand");
            check_bytes("rand");
            check("rand_frame_cnt", 32'(frame_cnt), exp_fc);
            check("rand_err_pulses", n_err - e0, nbad);
            check("rand_last_r", 32'(last_r), 32'(m_last));
        end

        check("total_timeouts", n_tmo, 3);
        check("never_both_ready", overlap, 0);
        check("err_dur_timing", err_bad_timing, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
